// File: rtl/locate_pkg.sv
// Shared definitions for the location-stream arbiter: register map, CTRL bit
// positions and the AXI4-Lite handshake state encodings.
package locate_pkg;

  localparam logic [11:0] CTRL_OFF  = 12'h000;
  localparam logic [11:0] FWD0_OFF  = 12'h004;
  localparam logic [11:0] FWD1_OFF  = 12'h008;
  localparam logic [11:0] DROP0_OFF = 12'h00C;
  localparam logic [11:0] DROP1_OFF = 12'h010;

  localparam int C0_EN_BIT = 0;
  localparam int C1_EN_BIT = 1;
  localparam int FIXED_BIT = 2;
  localparam int CLR_BIT   = 31;

  localparam logic [2:0] CTRL_RST  = 3'b011;
  localparam logic [1:0] RESP_OKAY = 2'b00;

  typedef enum logic [1:0] {AW_STATE, W_STATE, B_STATE} wr_state_t;
  typedef enum logic {AR_STATE, R_STATE} rd_state_t;

endpackage

// File: rtl/loc_slot.sv
// One-entry latest-value slot: a newer beat overwrites an unsent one and
// raises drop; a disabled slot discards beats and flushes its contents.
module loc_slot #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  input  logic              grant,
  output logic              full,
  output logic [DATA_W-1:0] data,
  output logic              drop
);

  // Reloading in the grant cycle hands the old value out, so it is not lost.
  assign drop = en && load && full && !grant;

  always_ff @(posedge clk) begin
    if (rst) begin
      full <= 1'b0;
      data <= '0;
    end else if (!en) begin
      full <= 1'b0;
    end else if (load) begin
      data <= load_data;
      full <= 1'b1;
    end else if (grant) begin
      full <= 1'b0;
    end
  end

endmodule

// File: rtl/loc_stream_arb.sv
// Merges the c0/c1 location feeds into one stream through per-channel
// overwrite slots, with round-robin or fixed-priority arbitration and AXI4-Lite stats.
module loc_stream_arb
  import locate_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 32,
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] c0_axis_tdata,
  input  logic              c0_axis_tvalid,
  output logic              c0_axis_tready,
  input  logic [DATA_W-1:0] c1_axis_tdata,
  input  logic              c1_axis_tvalid,
  output logic              c1_axis_tready,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic              m_axis_tuser,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  input  logic [31:0]       axil_s_awaddr,
  input  logic [2:0]        axil_s_awprot,
  input  logic              axil_s_awvalid,
  output logic              axil_s_awready,
  input  logic [31:0]       axil_s_wdata,
  input  logic [3:0]        axil_s_wstrb,
  input  logic              axil_s_wvalid,
  output logic              axil_s_wready,
  output logic [1:0]        axil_s_bresp,
  output logic              axil_s_bvalid,
  input  logic              axil_s_bready,
  input  logic [31:0]       axil_s_araddr,
  input  logic [2:0]        axil_s_arprot,
  input  logic              axil_s_arvalid,
  output logic              axil_s_arready,
  output logic [31:0]       axil_s_rdata,
  output logic [1:0]        axil_s_rresp,
  output logic              axil_s_rvalid,
  input  logic              axil_s_rready
);

  logic [2:0]        ctrl_reg;
  logic              cnt_clr;
  logic [1:0]        ch_valid, slot_full, slot_drop, req, grant;
  logic [DATA_W-1:0] ch_data   [2];
  logic [DATA_W-1:0] slot_data [2];
  logic [CNT_W-1:0]  fwd_reg   [2];
  logic [CNT_W-1:0]  drop_reg  [2];
  logic              rr_ptr_reg;
  logic              out_free;

  assign c0_axis_tready = 1'b1;
  assign c1_axis_tready = 1'b1;
  assign ch_valid   = {c1_axis_tvalid, c0_axis_tvalid};
  assign ch_data[0] = c0_axis_tdata;
  assign ch_data[1] = c1_axis_tdata;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_ch
      loc_slot #(.DATA_W(DATA_W)) u_slot (
        .clk       (clk),
        .rst       (rst),
        .en        (ctrl_reg[gi]),
        .load      (ch_valid[gi]),
        .load_data (ch_data[gi]),
        .grant     (grant[gi]),
        .full      (slot_full[gi]),
        .data      (slot_data[gi]),
        .drop      (slot_drop[gi])
      );

      // Saturating counters; a clear takes precedence over a same-cycle increment.
      always_ff @(posedge clk) begin
        if (rst || cnt_clr) begin
          fwd_reg[gi]  <= '0;
          drop_reg[gi] <= '0;
        end else begin
          if (grant[gi] && fwd_reg[gi] != '1)
            fwd_reg[gi] <= fwd_reg[gi] + 1'b1;
          if (slot_drop[gi] && drop_reg[gi] != '1)
            drop_reg[gi] <= drop_reg[gi] + 1'b1;
        end
      end
    end
  endgenerate

  // rr_ptr_reg names the channel that wins a tie in round-robin mode.
  assign req      = slot_full & ctrl_reg[1:0];
  assign out_free = !m_axis_tvalid || m_axis_tready;

  always_comb begin
    grant = 2'b00;
    if (out_free) begin
      if (req[0] && (!req[1] || ctrl_reg[FIXED_BIT] || !rr_ptr_reg))
        grant[0] = 1'b1;
      else if (req[1])
        grant[1] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tuser  <= 1'b0;
      rr_ptr_reg    <= 1'b0;
    end else if (|grant) begin
      m_axis_tvalid <= 1'b1;
      m_axis_tdata  <= grant[1] ? slot_data[1] : slot_data[0];
      m_axis_tuser  <= grant[1];
      rr_ptr_reg    <= grant[0];
    end else if (m_axis_tready) begin
      m_axis_tvalid <= 1'b0;
    end
  end

  // AXI4-Lite write path: AW, then W (register update), then B.
  wr_state_t         wr_state_reg, wr_state_next;
  logic [ADDR_W-1:0] wr_addr_reg;
  logic              wr_fire;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_state_reg <= AW_STATE;
      wr_addr_reg  <= '0;
    end else begin
      wr_state_reg <= wr_state_next;
      if (axil_s_awvalid && axil_s_awready)
        wr_addr_reg <= axil_s_awaddr[ADDR_W-1:0];
    end
  end

  always_comb begin
    wr_state_next  = wr_state_reg;
    axil_s_awready = 1'b0;
    axil_s_wready  = 1'b0;
    axil_s_bvalid  = 1'b0;
    case (wr_state_reg)
      AW_STATE: begin
        axil_s_awready = 1'b1;
        if (axil_s_awvalid) wr_state_next = W_STATE;
      end
      W_STATE: begin
        axil_s_wready = 1'b1;
        if (axil_s_wvalid) wr_state_next = B_STATE;
      end
      B_STATE: begin
        axil_s_bvalid = 1'b1;
        if (axil_s_bready) wr_state_next = AW_STATE;
      end
      default: wr_state_next = AW_STATE;
    endcase
  end

  assign axil_s_bresp = RESP_OKAY;
  assign wr_fire = (wr_state_reg == W_STATE) && axil_s_wvalid && (wr_addr_reg == ADDR_W'(CTRL_OFF));
  assign cnt_clr = wr_fire && axil_s_wdata[CLR_BIT];

  always_ff @(posedge clk) begin
    if (rst)          ctrl_reg <= CTRL_RST;
    else if (wr_fire) ctrl_reg <= axil_s_wdata[2:0];
  end

  // AXI4-Lite read path: data is captured on the AR handshake.
  rd_state_t   rd_state_reg, rd_state_next;
  logic [31:0] rd_value;

  always_comb begin
    rd_value = 32'h0;
    case (axil_s_araddr[ADDR_W-1:0])
      ADDR_W'(CTRL_OFF):  rd_value = {29'h0, ctrl_reg};
      ADDR_W'(FWD0_OFF):  rd_value = 32'(fwd_reg[0]);
      ADDR_W'(FWD1_OFF):  rd_value = 32'(fwd_reg[1]);
      ADDR_W'(DROP0_OFF): rd_value = 32'(drop_reg[0]);
      ADDR_W'(DROP1_OFF): rd_value = 32'(drop_reg[1]);
      default:            rd_value = 32'h0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_state_reg <= AR_STATE;
      axil_s_rdata <= 32'h0;
    end else begin
      rd_state_reg <= rd_state_next;
      if (axil_s_arvalid && axil_s_arready)
        axil_s_rdata <= rd_value;
    end
  end

  always_comb begin
    rd_state_next  = rd_state_reg;
    axil_s_arready = 1'b0;
    axil_s_rvalid  = 1'b0;
    case (rd_state_reg)
      AR_STATE: begin
        axil_s_arready = 1'b1;
        if (axil_s_arvalid) rd_state_next = R_STATE;
      end
      R_STATE: begin
        axil_s_rvalid = 1'b1;
        if (axil_s_rready) rd_state_next = AR_STATE;
      end
      default: rd_state_next = AR_STATE;
    endcase
  end

  assign axil_s_rresp = RESP_OKAY;

  logic unused_bits;
  assign unused_bits = ^{axil_s_awaddr, axil_s_araddr, axil_s_awprot, axil_s_arprot,
                         axil_s_wstrb, axil_s_wdata};

endmodule

// File: tb/tb_loc_stream_arb.sv
// Directed bench for loc_stream_arb: a cycle table for the basic and hold
// cases, plus hand-written sequences for arbitration, config and reset.
module tb_loc_stream_arb;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] c0_tdata = '0, c1_tdata = '0;
  logic        c0_tvalid = 1'b0, c1_tvalid = 1'b0;
  logic        c0_tready, c1_tready;
  logic [31:0] m_tdata;
  logic        m_tuser, m_tvalid;
  logic        m_tready = 1'b1;
  logic [31:0] awaddr = '0, wdata = '0, araddr = '0, rdata;
  logic        awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0, arvalid = 1'b0, rready = 1'b0;
  logic        awready, wready, bvalid, arready, rvalid;
  logic [1:0]  bresp, rresp;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  loc_stream_arb dut (
    .clk(clk), .rst(rst),
    .c0_axis_tdata(c0_tdata), .c0_axis_tvalid(c0_tvalid), .c0_axis_tready(c0_tready),
    .c1_axis_tdata(c1_tdata), .c1_axis_tvalid(c1_tvalid), .c1_axis_tready(c1_tready),
    .m_axis_tdata(m_tdata), .m_axis_tuser(m_tuser), .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready),
    .axil_s_awaddr(awaddr), .axil_s_awprot(3'b000), .axil_s_awvalid(awvalid), .axil_s_awready(awready),
    .axil_s_wdata(wdata), .axil_s_wstrb(4'hF), .axil_s_wvalid(wvalid), .axil_s_wready(wready),
    .axil_s_bresp(bresp), .axil_s_bvalid(bvalid), .axil_s_bready(bready),
    .axil_s_araddr(araddr), .axil_s_arprot(3'b000), .axil_s_arvalid(arvalid), .axil_s_arready(arready),
    .axil_s_rdata(rdata), .axil_s_rresp(rresp), .axil_s_rvalid(rvalid), .axil_s_rready(rready)
  );

  typedef struct {
    logic        c0_v;
    logic [31:0] c0_d;
    logic        c1_v;
    logic [31:0] c1_d;
    logic        rdy;
    logic        exp_v;
    logic [31:0] exp_d;
    logic        exp_u;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end else begin
      $display("ok   %s: 0x%08h", name, act);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_vec++;
    n_bad++;
    $display("FAIL %s: handshake timed out, expected completion within 20 cycles", name);
  endtask

  // All tasks start and end just after a rising edge.
  task automatic axil_write(input logic [31:0] a, input logic [31:0] d);
    int n;
    awaddr = a; awvalid = 1'b1; n = 0;
    @(negedge clk);
    while (!awready && n < 20) begin @(negedge clk); n++; end
    if (!awready) timeout_fail("aw");
    @(posedge clk); #1 awvalid = 1'b0; wdata = d; wvalid = 1'b1; n = 0;
    @(negedge clk);
    while (!wready && n < 20) begin @(negedge clk); n++; end
    if (!wready) timeout_fail("w");
    @(posedge clk); #1 wvalid = 1'b0; bready = 1'b1; n = 0;
    @(negedge clk);
    while (!bvalid && n < 20) begin @(negedge clk); n++; end
    if (!bvalid) timeout_fail("b");
    check("bresp", 32'(bresp), 32'h0);
    @(posedge clk); #1 bready = 1'b0;
  endtask

  task automatic axil_read(input logic [31:0] a, output logic [31:0] d);
    int n;
    araddr = a; arvalid = 1'b1; n = 0;
    @(negedge clk);
    while (!arready && n < 20) begin @(negedge clk); n++; end
    if (!arready) timeout_fail("ar");
    @(posedge clk); #1 arvalid = 1'b0; rready = 1'b1; n = 0;
    @(negedge clk);
    while (!rvalid && n < 20) begin @(negedge clk); n++; end
    if (!rvalid) timeout_fail("r");
    d = rdata;
    check("rresp", 32'(rresp), 32'h0);
    @(posedge clk); #1 rready = 1'b0;
  endtask

  task automatic read_check(input string name, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] d;
    axil_read(a, d);
    check(name, d, exp);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_m_tvalid"}, 32'(m_tvalid), 32'h0);
    check({tag, "_m_tdata"},  m_tdata, 32'h0);
    check({tag, "_m_tuser"},  32'(m_tuser), 32'h0);
    check({tag, "_awready"},  32'(awready), 32'h1);
    check({tag, "_arready"},  32'(arready), 32'h1);
    check({tag, "_wready"},   32'(wready), 32'h0);
    check({tag, "_bvalid"},   32'(bvalid), 32'h0);
    check({tag, "_rvalid"},   32'(rvalid), 32'h0);
    check({tag, "_rdata"},    rdata, 32'h0);
  endtask

  initial begin
    int cnt0, cnt1, beats, seen;
    logic exp_u;

    vecs[0]  = '{1'b1, 32'h00120034, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0};
    vecs[1]  = '{1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0};
    vecs[2]  = '{1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h00120034, 1'b0};
    vecs[3]  = '{1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h00120034, 1'b0};
    vecs[4]  = '{1'b0, 32'h0, 1'b1, 32'h0A0A0001, 1'b0, 1'b0, 32'h00120034, 1'b0};
    vecs[5]  = '{1'b0, 32'h0, 1'b1, 32'h0B0B0002, 1'b0, 1'b0, 32'h00120034, 1'b0};
    vecs[6]  = '{1'b0, 32'h0, 1'b1, 32'h0C0C0003, 1'b0, 1'b1, 32'h0A0A0001, 1'b1};
    vecs[7]  = '{1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0A0A0001, 1'b1};
    vecs[8]  = '{1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h0A0A0001, 1'b1};
    vecs[9]  = '{1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h0C0C0003, 1'b1};
    vecs[10] = '{1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0C0C0003, 1'b1};

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("rst");
    check("c0_tready", 32'(c0_tready), 32'h1);
    check("c1_tready", 32'(c1_tready), 32'h1);
    @(posedge clk); #1;
    read_check("rst_ctrl", 32'h000, 32'h3);
    read_check("rst_fwd0", 32'h004, 32'h0);
    read_check("rst_drop1", 32'h010, 32'h0);

    // Single c0 beat, then c1 beats held behind ready=0.
    for (int i = 0; i < 11; i++) begin
      c0_tvalid = vecs[i].c0_v; c0_tdata = vecs[i].c0_d;
      c1_tvalid = vecs[i].c1_v; c1_tdata = vecs[i].c1_d;
      m_tready  = vecs[i].rdy;
      @(negedge clk);
      check($sformatf("vec%0d_tvalid", i), 32'(m_tvalid), 32'(vecs[i].exp_v));
      check($sformatf("vec%0d_tdata", i), m_tdata, vecs[i].exp_d);
      check($sformatf("vec%0d_tuser", i), 32'(m_tuser), 32'(vecs[i].exp_u));
      @(posedge clk); #1;
    end
    c0_tvalid = 1'b0; c1_tvalid = 1'b0; m_tready = 1'b1;
    read_check("t1_fwd0", 32'h004, 32'd1);
    read_check("t3_fwd1", 32'h008, 32'd2);
    read_check("t3_drop0", 32'h00C, 32'd0);
    read_check("t3_drop1", 32'h010, 32'd1);

    // Counter clear and unmapped read.
    axil_write(32'h000, 32'h80000003);
    read_check("t5_ctrl", 32'h000, 32'h3);
    read_check("t5_fwd0", 32'h004, 32'h0);
    read_check("t5_fwd1", 32'h008, 32'h0);
    read_check("t5_drop0", 32'h00C, 32'h0);
    read_check("t5_drop1", 32'h010, 32'h0);
    read_check("t5_unmapped", 32'h020, 32'h0);

    // Round-robin with both channels always valid: 100 granted beats.
    cnt0 = 0; cnt1 = 0; exp_u = 1'b0;
    for (int cyc = 0; cyc < 107; cyc++) begin
      c0_tvalid = (cyc < 99); c0_tdata = 32'(cyc);
      c1_tvalid = (cyc < 99); c1_tdata = 32'h10000000 | 32'(cyc);
      @(negedge clk);
      if (m_tvalid) begin
        check("t2_tuser", 32'(m_tuser), 32'(exp_u));
        check("t2_src", 32'(m_tdata[31:28]), 32'(exp_u));
        if (m_tuser) cnt1++; else cnt0++;
        exp_u = !exp_u;
      end
      @(posedge clk); #1;
    end
    check("t2_cnt0", 32'(cnt0), 32'd50);
    check("t2_cnt1", 32'(cnt1), 32'd50);
    read_check("t2_fwd0", 32'h004, 32'd50);
    read_check("t2_fwd1", 32'h008, 32'd50);
    read_check("t2_drop0", 32'h00C, 32'd49);

    // Fixed priority with c1 disabled, then c0 disabled.
    axil_write(32'h000, 32'h5);
    beats = 0;
    for (int cyc = 0; cyc < 30; cyc++) begin
      c0_tvalid = (cyc < 24); c0_tdata = 32'h00C00000 | 32'(cyc);
      c1_tvalid = (cyc < 24); c1_tdata = 32'h10C00000 | 32'(cyc);
      @(negedge clk);
      if (m_tvalid) begin
        check("t4_tuser", 32'(m_tuser), 32'h0);
        beats++;
      end
      @(posedge clk); #1;
    end
    check("t4_beats", 32'(beats), 32'd24);
    read_check("t4_fwd0", 32'h004, 32'd74);
    axil_write(32'h000, 32'h2);
    seen = 0;
    for (int cyc = 0; cyc < 10; cyc++) begin
      c0_tvalid = 1'b1; c0_tdata = 32'h00D00000 | 32'(cyc);
      @(negedge clk);
      if (m_tvalid) seen++;
      @(posedge clk); #1;
    end
    c0_tvalid = 1'b0;
    check("t4_c0_discarded", 32'(seen), 32'd0);
    read_check("t4_drop0", 32'h00C, 32'd49);
    read_check("t4_fwd0_hold", 32'h004, 32'd74);

    // Reset while the write FSM waits for W and an output beat is held.
    axil_write(32'h000, 32'h3);
    m_tready = 1'b0;
    c0_tvalid = 1'b1; c0_tdata = 32'h00E00001;
    @(posedge clk); #1 c0_tvalid = 1'b0;
    repeat (2) @(posedge clk);
    #1 awaddr = 32'h000; awvalid = 1'b1;
    @(negedge clk);
    check("t6_m_tvalid_pre", 32'(m_tvalid), 32'h1);
    check("t6_awready_pre", 32'(awready), 32'h1);
    @(posedge clk); #1 awvalid = 1'b0;
    @(negedge clk);
    check("t6_wready_pre", 32'(wready), 32'h1);
    rst = 1'b1; wvalid = 1'b1; wdata = 32'h0;
    @(negedge clk);
    check_reset_outputs("t6");
    @(posedge clk); #1 rst = 1'b0;
    seen = 0;
    for (int cyc = 0; cyc < 3; cyc++) begin
      @(negedge clk);
      if (bvalid) seen++;
      @(posedge clk); #1;
    end
    wvalid = 1'b0; m_tready = 1'b1;
    check("t6_no_bvalid", 32'(seen), 32'd0);
    read_check("t6_ctrl", 32'h000, 32'h3);
    read_check("t6_fwd0", 32'h004, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
